// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Optional 50% duty feature is selected with macro CLKDIV_DUTY50_EN.
package clk_div_pkg;

  // Ratios below this value bypass the divider and pass the reference clock
  localparam int BYPASS_THRESH = 2;

  // LSB position of channel ch inside a packed NCH*W ratio bus
  function automatic int ratio_lsb(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Per-channel divider bundle: enable/ratio request in, divided clock and status out.
// Shared by all builds, with or without CLKDIV_DUTY50_EN.
interface clk_div_multi_if #(
  parameter int W = 8
);
  logic         clk_en;
  logic [W-1:0] div_ratio;
  logic         div_clk;
  logic         period_start;
  logic [W-1:0] ratio_active;

  modport master (
    output clk_en, div_ratio,
    input  div_clk, period_start, ratio_active
  );

  modport slave (
    input  clk_en, div_ratio,
    output div_clk, period_start, ratio_active
  );
endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: counter, registered divided clock, ratio shadow and bypass mux.
// Defining CLKDIV_DUTY50_EN adds a falling-edge flop that stretches odd ratios to 50% duty.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           i_ref_clk,
  input  logic           i_rst_n,
  clk_div_multi_if.slave ch
);

  localparam logic [W-1:0] THRESH = W'(BYPASS_THRESH);
  localparam logic [W-1:0] ONE    = W'(1);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] ratio_q, ratio_d;
  logic         div_q, div_d;
  logic         en_q;
  logic         bypass;
  logic         terminal;
  logic         div_shaped;

  // en_q keeps the channel bypassed until a load edge has seen the enable high,
  // so a rising enable always starts a clean period at cnt=0 with the output high.
  assign bypass   = !ch.clk_en || !en_q || (ratio_q < THRESH);
  assign terminal = (cnt_q == (ratio_q - ONE));

  always_comb begin
    ratio_d = ratio_q;
    cnt_d   = '0;
    if (bypass || terminal) begin
      ratio_d = ch.div_ratio;
    end else begin
      cnt_d = cnt_q + ONE;
    end
    div_d = ch.clk_en && (cnt_d < (ratio_d >> 1));
  end

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q   <= '0;
      ratio_q <= '0;
      div_q   <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ratio_q <= ratio_d;
      div_q   <= div_d;
      en_q    <= ch.clk_en;
    end
  end

`ifdef CLKDIV_DUTY50_EN
  logic div_fall_q;

  always_ff @(negedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_fall_q <= 1'b0;
    end else begin
      div_fall_q <= div_q;
    end
  end

  // Half-cycle extension only for odd ratios; even ratios are already symmetric
  assign div_shaped = div_q | (ratio_q[0] & div_fall_q);
`else
  assign div_shaped = div_q;
`endif

  assign ch.div_clk      = bypass ? i_ref_clk : div_shaped;
  assign ch.period_start = !bypass && (cnt_q == '0);
  assign ch.ratio_active = ratio_q;

endmodule

// File: rtl/clk_div_multi.sv
// NCH independent programmable clock dividers sharing one reference clock.
// Build option CLKDIV_DUTY50_EN gives 50% duty on odd ratios (see clk_div_chan).
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W   = 8
) (
  input  logic             i_ref_clk,
  input  logic             i_rst_n,
  input  logic [NCH-1:0]   i_clk_en,
  input  logic [NCH*W-1:0] i_div_ratio,
  output logic [NCH-1:0]   o_div_clk,
  output logic [NCH-1:0]   o_period_start,
  output logic [NCH*W-1:0] o_ratio_active
);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    clk_div_multi_if #(.W(W)) ch_if ();

    assign ch_if.clk_en    = i_clk_en[gi];
    assign ch_if.div_ratio = i_div_ratio[ratio_lsb(gi, W) +: W];

    assign o_div_clk[gi]                         = ch_if.div_clk;
    assign o_period_start[gi]                    = ch_if.period_start;
    assign o_ratio_active[ratio_lsb(gi, W) +: W] = ch_if.ratio_active;

    clk_div_chan #(.W(W)) u_chan (
      .i_ref_clk (i_ref_clk),
      .i_rst_n   (i_rst_n),
      .ch        (ch_if)
    );
  end

endmodule
